// File: rtl/sum_monitor.sv
// Receive-side checker for a W-bit registered adder: queues (a+b) mod 2^W per
// accepted operand pair and scores each result beat against the FIFO head.
module sum_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         y,
  output logic [$clog2(DEPTH):0]   pend,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         wrap_cnt,
  output logic                     err_sticky,
  output logic                     unexp,
  output logic [WIDTH-1:0]         first_exp,
  output logic [WIDTH-1:0]         first_got
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PEND_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  wrap_q, wrap_d;
  logic              sticky_q, sticky_d;
  logic              unexp_q, unexp_d;
  logic [WIDTH-1:0]  first_exp_q, first_exp_d;
  logic [WIDTH-1:0]  first_got_q, first_got_d;

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  head;
  logic              push, pop, mism;

  assign op_ready = (pend_q != PEND_MAX);

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    head = mem_q[rd_ptr_q];
    // clr wins over any handshake in the same cycle
    push = op_valid && op_ready && !clr;
    pop  = res_valid && (pend_q != '0) && !clr;
    // case inequality so an X/Z result is scored as a mismatch
    mism = (y !== head);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pend_d      = pend_q;
    match_d     = match_q;
    err_d       = err_q;
    wrap_d      = wrap_q;
    sticky_d    = sticky_q;
    unexp_d     = unexp_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pend_d      = '0;
      match_d     = '0;
      err_d       = '0;
      wrap_d      = '0;
      sticky_d    = 1'b0;
      unexp_d     = 1'b0;
      first_exp_d = '0;
      first_got_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (sum[WIDTH]) wrap_d = sat_inc(wrap_q);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (mism) begin
          err_d = sat_inc(err_q);
          if (!sticky_q) begin
            sticky_d    = 1'b1;
            first_exp_d = head;
            first_got_d = y;
          end
        end else begin
          match_d = sat_inc(match_q);
        end
      end
      // an entry written this edge cannot satisfy a result on the same edge
      if (res_valid && (pend_q == '0)) unexp_d = 1'b1;
      case ({push, pop})
        2'b10:   pend_d = pend_q + PEND_ONE;
        2'b01:   pend_d = pend_q - PEND_ONE;
        default: pend_d = pend_q;
      endcase
    end
  end

  // Storage needs no reset: only slots below pend are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= '0;
      match_q     <= '0;
      err_q       <= '0;
      wrap_q      <= '0;
      sticky_q    <= 1'b0;
      unexp_q     <= 1'b0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      match_q     <= match_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      sticky_q    <= sticky_d;
      unexp_q     <= unexp_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  assign pend       = pend_q;
  assign match_cnt  = match_q;
  assign err_cnt    = err_q;
  assign wrap_cnt   = wrap_q;
  assign err_sticky = sticky_q;
  assign unexp      = unexp_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;

endmodule

// File: tb/tb_sum_monitor.sv
// Bench for sum_monitor: queue-based reference model, per-cycle output compare,
// directed scenarios with literal expectations, then a randomized soak.
module tb_sum_monitor;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             res_valid = 1'b0;
  logic [WIDTH-1:0] y = '0;
  logic [$clog2(DEPTH):0] pend;
  logic [CNT_W-1:0] match_cnt, err_cnt, wrap_cnt;
  logic             err_sticky, unexp;
  logic [WIDTH-1:0] first_exp, first_got;

  sum_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .op_valid(op_valid), .op_ready(op_ready), .a(a), .b(b),
    .res_valid(res_valid), .y(y), .pend(pend),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
    .err_sticky(err_sticky), .unexp(unexp),
    .first_exp(first_exp), .first_got(first_got)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_q[$];
  int m_match = 0, m_err = 0, m_wrap = 0;
  bit m_sticky = 0, m_unexp = 0;
  int m_fexp = 0, m_fgot = 0;

  task automatic model_clear();
    m_q.delete();
    m_match = 0; m_err = 0; m_wrap = 0;
    m_sticky = 0; m_unexp = 0; m_fexp = 0; m_fgot = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else if (clr) begin
      model_clear();
    end else begin
      int sz;
      int unsigned s, h;
      sz = m_q.size();
      if (res_valid) begin
        if (sz > 0) begin
          h = m_q.pop_front();
          if (y === WIDTH'(h)) begin
            if (m_match < CMAX) m_match++;
          end else begin
            if (m_err < CMAX) m_err++;
            if (!m_sticky) begin
              m_sticky = 1; m_fexp = h; m_fgot = y;
            end
          end
        end else begin
          m_unexp = 1;
        end
      end
      if (op_valid && sz != DEPTH) begin
        s = a + b;
        m_q.push_back(s % (1 << WIDTH));
        if (s >= (1 << WIDTH) && m_wrap < CMAX) m_wrap++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pend",       32'(pend),       32'(m_q.size()));
      chk("op_ready",   32'(op_ready),   32'(m_q.size() != DEPTH));
      chk("match_cnt",  32'(match_cnt),  32'(m_match));
      chk("err_cnt",    32'(err_cnt),    32'(m_err));
      chk("wrap_cnt",   32'(wrap_cnt),   32'(m_wrap));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("unexp",      32'(unexp),      32'(m_unexp));
      chk("first_exp",  32'(first_exp),  32'(m_fexp));
      chk("first_got",  32'(first_got),  32'(m_fgot));
    end
  end

  // One-cycle beat: inputs applied at a falling edge, sampled at the next
  // rising edge, results visible at the following falling edge.
  task automatic step(input bit ov, input int aa, input int bb,
                      input bit rv, input int yy, input bit cl);
    op_valid = ov; a = WIDTH'(aa); b = WIDTH'(bb);
    res_valid = rv; y = WIDTH'(yy); clr = cl;
    @(negedge clk);
    op_valid = 0; res_valid = 0; clr = 0;
  endtask

  task automatic push(input int aa, input int bb);
    step(1, aa, bb, 0, 0, 0);
  endtask

  task automatic res(input int yy);
    step(0, 0, 0, 1, yy, 0);
  endtask

  initial begin
    // reset held for two cycles
    rst_n = 0;
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("rst pend", 32'(pend), 0);
    chk("rst op_ready", 32'(op_ready), 1);
    chk("rst counters", 32'(match_cnt | err_cnt | wrap_cnt), 0);
    chk("rst flags", 32'({err_sticky, unexp}), 0);

    // basic match
    push(1, 2);
    chk("basic pend1", 32'(pend), 1);
    res(3);
    chk("basic match", 32'(match_cnt), 1);
    chk("basic err", 32'(err_cnt), 0);
    chk("basic pend0", 32'(pend), 0);

    // carry-out
    push(255, 1);
    res(0);
    chk("wrap cnt", 32'(wrap_cnt), 1);
    chk("wrap match", 32'(match_cnt), 2);
    push(8'hAA, 8'h55);
    res(8'hFF);
    chk("nowrap cnt", 32'(wrap_cnt), 1);
    chk("nowrap match", 32'(match_cnt), 3);

    // mismatch and first-failure capture
    push(10, 20);
    res(31);
    chk("mis err", 32'(err_cnt), 1);
    chk("mis sticky", 32'(err_sticky), 1);
    chk("mis first_exp", 32'(first_exp), 30);
    chk("mis first_got", 32'(first_got), 31);
    push(1, 1);
    res(5);
    chk("mis2 err", 32'(err_cnt), 2);
    chk("mis2 first_exp", 32'(first_exp), 30);
    chk("mis2 first_got", 32'(first_got), 31);

    // full FIFO and ordering
    push(1, 1); push(2, 2); push(3, 3); push(4, 4);
    chk("full pend", 32'(pend), 4);
    chk("full ready", 32'(op_ready), 0);
    push(9, 9);
    chk("dropped pend", 32'(pend), 4);
    step(1, 5, 5, 1, 2, 0);
    chk("full push+pop pend", 32'(pend), 3);
    res(4); res(6); res(8);
    chk("order match", 32'(match_cnt), 7);
    chk("order pend", 32'(pend), 0);
    chk("order wrap", 32'(wrap_cnt), 1);

    // simultaneous push and pop with one entry queued
    push(2, 3);
    step(1, 4, 4, 1, 5, 0);
    chk("pp pend", 32'(pend), 1);
    res(8);
    chk("pp match", 32'(match_cnt), 9);

    // unexpected result, then clear racing a push
    res(7);
    chk("unexp flag", 32'(unexp), 1);
    chk("unexp match", 32'(match_cnt), 9);
    chk("unexp err", 32'(err_cnt), 2);
    step(1, 3, 3, 0, 0, 1);
    chk("clr pend", 32'(pend), 0);
    chk("clr unexp", 32'(unexp), 0);
    chk("clr counts", 32'(match_cnt | err_cnt | wrap_cnt), 0);
    chk("clr sticky", 32'(err_sticky), 0);

    // push in the same cycle as an unmatched result
    step(1, 1, 1, 1, 2, 0);
    chk("same-cycle unexp", 32'(unexp), 1);
    chk("same-cycle pend", 32'(pend), 1);
    res(2);
    chk("same-cycle match", 32'(match_cnt), 1);

    // async reset with entries queued
    push(1, 2); push(3, 4); push(5, 6);
    chk("pre-rst pend", 32'(pend), 3);
    #2 rst_n = 0;
    #1 chk("async rst pend", 32'(pend), 0);
    chk("async rst match", 32'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1;

    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      bit ov, rv, cl;
      int yy;
      ov = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 50);
      cl = ($urandom_range(0, 199) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 99) < 85) yy = int'(m_q[0]);
      else yy = int'($urandom_range(0, 255));
      step(ov, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rv, yy, cl);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
